reg_dump_unit: RTL and testbench
================================

// Module: reg_dump_unit
// PURPOSE
//  Reads out the register file once the core signals program end, and streams each register to a consumer.
//  Sits beside SINGLE_CORE, watches end_signal_out and shares a read-only port into the register file.
//  Emits an {index, value} stream under a valid/ready handshake, for a host link or a bench scoreboard.
//  Replaces the task-based display_regs() dump with synthesizable hardware.
// PARAMETERS
//  DATA_W     32  register width
//  ADDR_W     5   register index width
//  FIRST_REG  0   first index dumped
//  LAST_REG   31  last index dumped; FIRST_REG <= LAST_REG < 2**ADDR_W
// PORTS
//  clock            in   1       system clock; all state updates on posedge
//  reset            in   1       synchronous, active-high reset
//  end_signal_in    in   1       from the core's end_signal_out
//  rf_read_en_out   out  1       register-file read strobe
//  rf_read_addr_out out  ADDR_W  register index being read
//  rf_read_data_in  in   DATA_W  read data, valid exactly 1 cycle after the strobe
//  dump_valid_out   out  1       output beat valid
//  dump_ready_in    in   1       consumer accepts the beat
//  dump_index_out   out  ADDR_W  register index of the beat
//  dump_data_out    out  DATA_W  register value of the beat
//  dump_last_out    out  1       beat carries LAST_REG
//  busy_out         out  1       dump in progress
//  done_out         out  1       sticky: a full dump has completed
// BEHAVIOUR
//  Reset values: every output is 0; state=IDLE; armed=0; idx=FIRST_REG.
//  Arming:
//   - armed is set on any cycle where end_signal_in=0.
//   - trigger = armed & end_signal_in & !end_q, where end_q is end_signal_in delayed by 1 cycle.
//   - end_signal_in held high out of reset therefore does NOT trigger; the input must first go low, then rise.
//  FSM:
//   - IDLE: on trigger, clear done_out, set idx=FIRST_REG, go to READ.
//   - READ (1 cycle): rf_read_en_out=1 and rf_read_addr_out=idx; go to CAPT.
//   - CAPT (1 cycle): load dump_data_out=rf_read_data_in and dump_index_out=idx;
//     set dump_last_out=(idx==LAST_REG); set dump_valid_out=1; go to SEND.
//   - SEND: hold valid, index, data and last stable until dump_valid_out & dump_ready_in.
//     On that handshake, drop valid.
//     If last: set done_out, clear armed, go to IDLE.
//     Otherwise: idx+=1, go to READ.
//  Throughput and latency:
//   - One beat per 3 cycles minimum; ready stalls extend SEND indefinitely.
//   - First beat is valid 3 cycles after the trigger cycle: trigger at cycle t, READ at t+1, CAPT at t+2, valid at t+3.
//  Ordering and contents:
//   - idx is ADDR_W wide and never wraps; the dump stops at LAST_REG.
//   - Exactly LAST_REG-FIRST_REG+1 beats per dump, in ascending index order.
//  Other rules:
//   - busy_out=1 in any state other than IDLE.
//   - Triggers that arrive while busy are ignored; no queuing.
//   - rf_read_en_out=0 outside READ; rf_read_addr_out holds its last value.
//   - dump_ready_in is ignored while dump_valid_out=0.
//   - A ready that is already high when valid rises completes the beat in that same cycle.
//   - Reset mid-dump: next cycle is IDLE with valid=0 and done=0; a partial dump is never resumed.
//   - A rising edge on end_signal_in coincident with reset is discarded.
//   - Register values are sampled at read time; the core is halted after end, so no coherence logic is needed.
// STRUCTURE
//  Package DUMP_PKG holds:
//   - typedef enum logic [1:0] {IDLE, READ, CAPT, SEND} dump_state_t;
//   - typedef struct packed {logic [4:0] index; logic [31:0] data; logic last;} dump_beat_t;
//  Sub-module end_edge_detect (clock, reset, level_in, rise_out):
//   - Owns end_q and armed.
//   - Is reused for the core's start/communication signals.
//  FSM, idx counter and output register live in the top module.
// TESTING
//  - Hold end=1 out of reset for 5 cycles -> no rf_read_en, busy=0, done=0.
//  - Regs $1=4, $2=5, $3=5, $4=24 (factorial-of-4 end state); end 0->1 with ready tied 1
//    -> 32 beats, index 0..31, beat 4 data=24, last only on index 31;
//    done=1 at beat 31 + 1 cycle; first valid 3 cycles after the edge.
//  - ready low 7 cycles on beat 2 -> index=2 and data held stable all 7 cycles, no extra rf reads,
//    beat count still 32.
//  - Second 0->1 end pulse during beat 10 -> ignored, exactly 32 beats; a later pulse after done
//    -> a new dump with done cleared.
//  - Assert reset during beat 17 -> next cycle valid=0, busy=0, done=0;
//    a fresh 0->1 edge restarts at index 0.
//  - FIRST_REG=4, LAST_REG=7 -> exactly 4 beats, indices 4..7, last on 7.

Source files
------------

// File: rtl/dump_pkg.sv
// Shared types for the register-dump block: FSM state encoding and the beat payload.
package dump_pkg;

   localparam int unsigned DUMP_DATA_W = 32;
   localparam int unsigned DUMP_ADDR_W = 5;

   typedef enum logic [1:0] {IDLE, READ, CAPT, SEND} dump_state_t;

   typedef struct packed {
      logic [DUMP_ADDR_W-1:0] index;
      logic [DUMP_DATA_W-1:0] data;
      logic                   last;
   } dump_beat_t;

endpackage

// File: rtl/reg_dump_unit_edge.sv
// Armed rising-edge detector; a level that is already high out of reset must drop
// low before a rise counts. Also used for the core's start/communication strobes.
module end_edge_detect (
   input  logic clock,
   input  logic reset,
   input  logic level_in,
   input  logic clear_in,
   output logic rise_out
);

   logic level_q;
   logic armed_q;

   // A low level re-arms; set wins over clear in the same cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         level_q <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         level_q <= level_in;
         if (!level_in) begin
            armed_q <= 1'b1;
         end else if (clear_in) begin
            armed_q <= 1'b0;
         end
      end
   end

   // Combinational so the FSM can leave IDLE on the trigger cycle itself.
   always_comb begin
      rise_out = armed_q & level_in & ~level_q;
   end

endmodule

// File: rtl/reg_dump_unit.sv
// Dumps registers FIRST_REG..LAST_REG after the core's end strobe rises, one
// {index, value} beat at a time under valid/ready.
module reg_dump_unit
   import dump_pkg::*;
#(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned ADDR_W    = 5,
   parameter int unsigned FIRST_REG = 0,
   parameter int unsigned LAST_REG  = 31
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              end_signal_in,
   output logic              rf_read_en_out,
   output logic [ADDR_W-1:0] rf_read_addr_out,
   input  logic [DATA_W-1:0] rf_read_data_in,
   output logic              dump_valid_out,
   input  logic              dump_ready_in,
   output logic [ADDR_W-1:0] dump_index_out,
   output logic [DATA_W-1:0] dump_data_out,
   output logic              dump_last_out,
   output logic              busy_out,
   output logic              done_out
);

   localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(FIRST_REG);
   localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(LAST_REG);

   dump_state_t       state_q;
   dump_state_t       state_d;
   logic [ADDR_W-1:0] idx_q;
   logic [ADDR_W-1:0] idx_d;
   logic              trigger;
   logic              clear_armed;

   logic              rd_en_d;
   logic [ADDR_W-1:0] rd_addr_d;
   logic              valid_d;
   logic [ADDR_W-1:0] index_d;
   logic [DATA_W-1:0] data_d;
   logic              last_d;
   logic              done_d;

   end_edge_detect u_end_edge (
      .clock    (clock),
      .reset    (reset),
      .level_in (end_signal_in),
      .clear_in (clear_armed),
      .rise_out (trigger)
   );

   // State and index registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q   <= FIRST_IDX;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // Next state plus next values of every registered output.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      clear_armed = 1'b0;
      rd_en_d     = 1'b0;
      rd_addr_d   = rf_read_addr_out;
      valid_d     = dump_valid_out;
      index_d     = dump_index_out;
      data_d      = dump_data_out;
      last_d      = dump_last_out;
      done_d      = done_out;

      case (state_q)
         IDLE: begin
            if (trigger) begin
               done_d    = 1'b0;
               idx_d     = FIRST_IDX;
               rd_en_d   = 1'b1;
               rd_addr_d = FIRST_IDX;
               state_d   = READ;
            end
         end
         READ: begin
            state_d = CAPT;
         end
         CAPT: begin
            data_d  = rf_read_data_in;
            index_d = idx_q;
            last_d  = (idx_q == LAST_IDX);
            valid_d = 1'b1;
            state_d = SEND;
         end
         SEND: begin
            if (dump_valid_out && dump_ready_in) begin
               valid_d = 1'b0;
               if (dump_last_out) begin
                  done_d      = 1'b1;
                  clear_armed = 1'b1;
                  state_d     = IDLE;
               end else begin
                  idx_d     = idx_q + ADDR_W'(1);
                  rd_en_d   = 1'b1;
                  rd_addr_d = idx_q + ADDR_W'(1);
                  state_d   = READ;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output register; busy follows the state being entered so it lines up with it.
   always_ff @(posedge clock) begin
      if (reset) begin
         rf_read_en_out   <= 1'b0;
         rf_read_addr_out <= '0;
         dump_valid_out   <= 1'b0;
         dump_index_out   <= '0;
         dump_data_out    <= '0;
         dump_last_out    <= 1'b0;
         busy_out         <= 1'b0;
         done_out         <= 1'b0;
      end else begin
         rf_read_en_out   <= rd_en_d;
         rf_read_addr_out <= rd_addr_d;
         dump_valid_out   <= valid_d;
         dump_index_out   <= index_d;
         dump_data_out    <= data_d;
         dump_last_out    <= last_d;
         busy_out         <= (state_d != IDLE);
         done_out         <= done_d;
      end
   end

endmodule

// File: tb/tb_reg_dump_unit.sv
// Bench for reg_dump_unit: scenario table plus randomized register contents and
// ready patterns, checked against an ascending-index reference dump.
module tb_reg_dump_unit;
   import dump_pkg::*;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 5;

   logic              clock = 1'b0;
   logic              reset;
   logic              end_sig, end2;
   logic              rf_read_en, rf_read_en2;
   logic [ADDR_W-1:0] rf_addr, rf_addr2;
   logic [DATA_W-1:0] rf_data, rf_data2;
   logic              valid, valid2;
   logic              ready, ready2;
   logic [ADDR_W-1:0] index, index2;
   logic [DATA_W-1:0] data, data2;
   logic              last, last2;
   logic              busy, busy2;
   logic              done, done2;

   logic [DATA_W-1:0] rf_mem [32];

   always #5 clock = ~clock;

   reg_dump_unit dut (
      .clock(clock), .reset(reset), .end_signal_in(end_sig),
      .rf_read_en_out(rf_read_en), .rf_read_addr_out(rf_addr), .rf_read_data_in(rf_data),
      .dump_valid_out(valid), .dump_ready_in(ready), .dump_index_out(index),
      .dump_data_out(data), .dump_last_out(last), .busy_out(busy), .done_out(done)
   );

   reg_dump_unit #(.FIRST_REG(4), .LAST_REG(7)) dut2 (
      .clock(clock), .reset(reset), .end_signal_in(end2),
      .rf_read_en_out(rf_read_en2), .rf_read_addr_out(rf_addr2), .rf_read_data_in(rf_data2),
      .dump_valid_out(valid2), .dump_ready_in(ready2), .dump_index_out(index2),
      .dump_data_out(data2), .dump_last_out(last2), .busy_out(busy2), .done_out(done2)
   );

   // Register file read port: data one cycle after the strobe, junk otherwise.
   always @(posedge clock) begin
      rf_data  <= rf_read_en  ? rf_mem[rf_addr]  : DATA_W'($urandom);
      rf_data2 <= rf_read_en2 ? rf_mem[rf_addr2] : DATA_W'($urandom);
   end

   typedef struct {
      bit rand_rf;
      int stall_beat;
      int stall_len;
      int ready_pct;
      int pulse_beat;
      int rst_beat;
      int exp_beats;
   } scen_t;

   typedef struct {
      int          beat;
      logic [31:0] data;
      logic        last;
   } fact_t;

   int         vectors = 0;
   int         miscompares = 0;
   dump_beat_t got[$];
   dump_beat_t got2[$];
   int         beat_n, stall_beat, stall_left, ready_pct, rd_cnt;
   bit         hold_v, exp_done_next;
   logic [4:0] hold_idx;
   logic [31:0] hold_data;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: sample #1 after the edge, choose ready, record accepted beats.
   task automatic tick();
      @(posedge clock);
      #1;
      if (rf_read_en) rd_cnt++;
      if (exp_done_next && !reset) begin
         chk("done_after_last", 64'(done), 64'd1);
         chk("idle_after_last", 64'(busy), 64'd0);
      end
      exp_done_next = 1'b0;
      if (hold_v && !reset) begin
         chk("stall_valid", 64'(valid), 64'd1);
         chk("stall_index", 64'(index), 64'(hold_idx));
         chk("stall_data",  64'(data),  64'(hold_data));
      end
      if (valid && beat_n == stall_beat && stall_left > 0) begin
         ready = 1'b0;
         stall_left--;
      end else begin
         ready = ($urandom_range(99) < ready_pct);
      end
      hold_v    = valid && !ready;
      hold_idx  = index;
      hold_data = data;
      if (valid && ready) begin
         got.push_back('{index, data, last});
         beat_n++;
         exp_done_next = last;
      end
      if (valid2 && ready2) got2.push_back('{index2, data2, last2});
   endtask

   task automatic run_dump(input scen_t s);
      bit pulsed, finished;
      int n;
      got.delete();
      beat_n     = 0;
      rd_cnt     = 0;
      stall_beat = s.stall_beat;
      stall_left = s.stall_len;
      ready_pct  = s.ready_pct;
      pulsed     = 1'b0;
      finished   = 1'b0;
      end_sig = 1'b0;
      tick();
      tick();
      end_sig = 1'b1;
      tick();
      chk("rd_en_t1",   64'(rf_read_en), 64'd1);
      chk("rd_addr_t1", 64'(rf_addr),    64'd0);
      chk("busy_t1",    64'(busy),       64'd1);
      tick();
      chk("rd_en_t2", 64'(rf_read_en), 64'd0);
      chk("valid_t2", 64'(valid),      64'd0);
      tick();
      chk("valid_t3", 64'(valid), 64'd1);
      chk("index_t3", 64'(index), 64'd0);
      chk("done_clr", 64'(done),  64'd0);
      for (int g = 0; g < 3000; g++) begin
         if (s.rst_beat >= 0 && beat_n == s.rst_beat) begin
            reset = 1'b1;
            tick();
            chk("rst_valid", 64'(valid), 64'd0);
            chk("rst_busy",  64'(busy),  64'd0);
            chk("rst_done",  64'(done),  64'd0);
            reset = 1'b0;
            finished = 1'b1;
            break;
         end
         if (s.pulse_beat >= 0 && beat_n == s.pulse_beat && !pulsed) begin
            pulsed  = 1'b1;
            end_sig = 1'b0;
            tick();
            end_sig = 1'b1;
         end
         if (done && !busy) begin
            finished = 1'b1;
            break;
         end
         tick();
      end
      chk("dump_finished", 64'(finished), 64'd1);
      chk("beat_count", 64'(got.size()), 64'(s.exp_beats));
      n = (got.size() < s.exp_beats) ? got.size() : s.exp_beats;
      for (int i = 0; i < n; i++) begin
         chk($sformatf("beat%0d_index", i), 64'(got[i].index), 64'(i));
         chk($sformatf("beat%0d_data", i),  64'(got[i].data),  64'(rf_mem[i]));
         chk($sformatf("beat%0d_last", i),  64'(got[i].last),  64'(i == 31));
      end
      if (s.rst_beat < 0) chk("rf_reads", 64'(rd_cnt), 64'd32);
   endtask

   scen_t tbl[7];
   fact_t fact[6];

   initial begin
      tbl[0] = '{1'b0, -1, 0, 100, -1, -1, 32};  // factorial end state, ready tied high
      tbl[1] = '{1'b1,  2, 7, 100, -1, -1, 32};  // ready low 7 cycles on beat 2
      tbl[2] = '{1'b1, -1, 0, 100, 10, -1, 32};  // second end pulse during beat 10
      tbl[3] = '{1'b1, -1, 0, 100, -1, -1, 32};  // new dump after done
      tbl[4] = '{1'b1, -1, 0,  50, -1, 17, 17};  // reset during beat 17
      tbl[5] = '{1'b1, -1, 0,  40, -1, -1, 32};  // restart from index 0
      tbl[6] = '{1'b1,  5, 3,  70, -1, -1, 32};
      fact[0] = '{0,  32'd0,  1'b0};
      fact[1] = '{1,  32'd4,  1'b0};
      fact[2] = '{2,  32'd5,  1'b0};
      fact[3] = '{3,  32'd5,  1'b0};
      fact[4] = '{4,  32'd24, 1'b0};
      fact[5] = '{31, 32'd0,  1'b1};

      reset = 1'b1; end_sig = 1'b1; end2 = 1'b1; ready = 1'b0; ready2 = 1'b1;
      ready_pct = 100; stall_beat = -1; stall_left = 0; beat_n = 0; rd_cnt = 0;
      hold_v = 1'b0; exp_done_next = 1'b0;
      for (int i = 0; i < 32; i++) rf_mem[i] = '0;
      rf_mem[1] = 32'd4; rf_mem[2] = 32'd5; rf_mem[3] = 32'd5; rf_mem[4] = 32'd24;

      repeat (3) tick();
      chk("rst_rd_en",   64'(rf_read_en), 64'd0);
      chk("rst_rd_addr", 64'(rf_addr),    64'd0);
      chk("rst_valid0",  64'(valid),      64'd0);
      chk("rst_index",   64'(index),      64'd0);
      chk("rst_data",    64'(data),       64'd0);
      chk("rst_last",    64'(last),       64'd0);
      chk("rst_busy0",   64'(busy),       64'd0);
      chk("rst_done0",   64'(done),       64'd0);

      // End held high straight out of reset must not start a dump.
      reset = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         chk("held_rd_en", 64'(rf_read_en), 64'd0);
         chk("held_busy",  64'(busy),       64'd0);
         chk("held_done",  64'(done),       64'd0);
      end
      chk("held_rd_cnt", 64'(rd_cnt), 64'd0);
      chk("held_dut2_busy", 64'(busy2), 64'd0);

      for (int t = 0; t < 7; t++) begin
         if (tbl[t].rand_rf) begin
            for (int i = 0; i < 32; i++) rf_mem[i] = $urandom;
         end
         run_dump(tbl[t]);
         if (t == 0) begin
            for (int k = 0; k < 6; k++) begin
               if (got.size() > fact[k].beat) begin
                  chk($sformatf("fact_data%0d", fact[k].beat), 64'(got[fact[k].beat].data), 64'(fact[k].data));
                  chk($sformatf("fact_last%0d", fact[k].beat), 64'(got[fact[k].beat].last), 64'(fact[k].last));
               end else begin
                  chk($sformatf("fact_present%0d", fact[k].beat), 64'(got.size()), 64'(fact[k].beat + 1));
               end
            end
         end
         if (tbl[t].rst_beat < 0) chk("done_sticky", 64'(done), 64'd1);
         tick();
      end

      // Narrow window instance: indices 4..7 only.
      for (int i = 0; i < 32; i++) rf_mem[i] = $urandom;
      got2.delete();
      ready_pct = 100;
      stall_beat = -1;
      end2 = 1'b0;
      tick();
      tick();
      end2 = 1'b1;
      for (int c = 0; c < 30; c++) tick();
      chk("win_beats", 64'(got2.size()), 64'd4);
      for (int i = 0; i < got2.size() && i < 4; i++) begin
         chk($sformatf("win%0d_index", i), 64'(got2[i].index), 64'(i + 4));
         chk($sformatf("win%0d_data", i),  64'(got2[i].data),  64'(rf_mem[i + 4]));
         chk($sformatf("win%0d_last", i),  64'(got2[i].last),  64'(i == 3));
      end
      chk("win_done", 64'(done2), 64'd1);
      chk("win_busy", 64'(busy2), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
